// File: rtl/instr_fetch_if.sv
// Fetch-stage bus bundle for the R.O.E core.
// Groups the control inputs, the instruction-memory port and the decoder-facing
// outputs of instr_fetch.
//   master : the fetch stage (drives imem_addr, instr, instr_valid, done, retired)
//   slave  : the surrounding core / memory / decoder (drives start, stall,
//            branch_taken, branch_offset, imem_data)
interface instr_fetch_if #(
  parameter int unsigned PC_W  = 10,
  parameter int unsigned CNT_W = 16
);
  logic             start;
  logic             stall;
  logic             branch_taken;
  logic [7:0]       branch_offset;
  logic [PC_W-1:0]  imem_addr;
  logic [8:0]       imem_data;
  logic [8:0]       instr;
  logic             instr_valid;
  logic             done;
  logic [CNT_W-1:0] retired;

  modport master (
    input  start, stall, branch_taken, branch_offset, imem_data,
    output imem_addr, instr, instr_valid, done, retired
  );

  modport slave (
    output start, stall, branch_taken, branch_offset, imem_data,
    input  imem_addr, instr, instr_valid, done, retired
  );
endinterface

// File: rtl/instr_fetch.sv
// Instruction fetch stage of the R.O.E core.
// Owns the program counter, addresses a combinational instruction memory and
// presents the fetched word to the control decoder in the same cycle. Handles
// BNZ redirects, HALT detection and a saturating retired-instruction count.
// Ports:
//   clk    - core clock, all state on rising edge
//   rst_n  - asynchronous active-low reset
//   bus    - instr_fetch_if.master: start/stall/branch inputs, imem_addr/imem_data,
//            instr/instr_valid to the decoder, done and retired status
// PC_W must be at least 8 (branch offset is sign-extended to PC_W).
module instr_fetch #(
  parameter int unsigned     PC_W       = 10,
  parameter logic [PC_W-1:0] START_PC   = '0,
  parameter logic [8:0]      HALT_INSTR = 9'h1FF,
  parameter int unsigned     CNT_W      = 16
) (
  input  logic           clk,
  input  logic           rst_n,
  instr_fetch_if.master  bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state, state_next;
  logic [PC_W-1:0]  pc, pc_next;
  logic [CNT_W-1:0] retired, retired_next;
  logic [PC_W-1:0]  offset_ext;

  assign offset_ext    = {{(PC_W-8){bus.branch_offset[7]}}, bus.branch_offset};
  assign bus.imem_addr = pc;
  assign bus.retired   = retired;
  assign bus.done      = (state == DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      pc      <= START_PC;
      retired <= '0;
    end else begin
      state   <= state_next;
      pc      <= pc_next;
      retired <= retired_next;
    end
  end

  always_comb begin
    state_next      = state;
    pc_next         = pc;
    retired_next    = retired;
    bus.instr       = '0;
    bus.instr_valid = 1'b0;
    case (state)
      IDLE, DONE: begin
        if (bus.start) begin
          pc_next      = START_PC;
          retired_next = '0;
          state_next   = RUN;
        end
      end
      RUN: begin
        bus.instr       = bus.imem_data;
        bus.instr_valid = ~bus.stall;
        // A stalled instruction re-presents next cycle, so its branch result
        // is only acted on once it actually commits.
        if (!bus.stall) begin
          if (retired != '1) begin
            retired_next = retired + CNT_W'(1);
          end
          if (bus.imem_data == HALT_INSTR) begin
            state_next = DONE;
          end else if (bus.branch_taken) begin
            pc_next = pc + offset_ext;
          end else begin
            pc_next = pc + PC_W'(1);
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_instr_fetch.sv
// Directed self-checking bench for instr_fetch.
module tb_instr_fetch;
  localparam int unsigned PC_W  = 10;
  localparam int unsigned CNT_W = 16;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  logic [8:0] imem [0:(1<<PC_W)-1];

  instr_fetch_if #(.PC_W(PC_W), .CNT_W(CNT_W)) bus ();

  instr_fetch #(
    .PC_W(PC_W),
    .START_PC(10'd0),
    .HALT_INSTR(9'h1FF),
    .CNT_W(CNT_W)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  assign bus.imem_data = imem[bus.imem_addr];

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_state(input string tag, input int addr, input logic valid,
                             input logic dn, input int ret);
    check({tag, ".addr"},    32'(bus.imem_addr),   32'(addr));
    check({tag, ".valid"},   32'(bus.instr_valid), 32'(valid));
    check({tag, ".done"},    32'(bus.done),        32'(dn));
    check({tag, ".retired"}, 32'(bus.retired),     32'(ret));
  endtask

  initial begin
    for (int i = 0; i < (1<<PC_W); i++) imem[i] = 9'h000;
    rst_n             = 1'b0;
    bus.start         = 1'b0;
    bus.stall         = 1'b0;
    bus.branch_taken  = 1'b0;
    bus.branch_offset = 8'h00;

    // Reset held for 3 cycles, then idle for 5
    #1;
    check_state("rst", 0, 1'b0, 1'b0, 0);
    check("rst.instr", 32'(bus.instr), 32'h0);
    repeat (3) tick();
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check_state("idle", 0, 1'b0, 1'b0, 0);
    end

    // Linear program ending in HALT
    imem[0] = 9'h040; imem[1] = 9'h081; imem[2] = 9'h0C2; imem[3] = 9'h1FF;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    check_state("lin0", 0, 1'b1, 1'b0, 0);
    check("lin0.instr", 32'(bus.instr), 32'h040);
    tick(); check_state("lin1", 1, 1'b1, 1'b0, 1);
    tick(); check_state("lin2", 2, 1'b1, 1'b0, 2);
    check("lin2.instr", 32'(bus.instr), 32'h0C2);
    tick(); check_state("lin3", 3, 1'b1, 1'b0, 3);
    check("lin3.instr", 32'(bus.instr), 32'h1FF);
    tick(); check_state("lin_done", 3, 1'b0, 1'b1, 4);
    tick(); check_state("lin_hold", 3, 1'b0, 1'b1, 4);

    // Restart from DONE into an all-NOP program
    for (int i = 0; i < (1<<PC_W); i++) imem[i] = 9'h000;
    bus.start = 1'b1;
    tick();
    check_state("restart", 0, 1'b1, 1'b0, 0);
    // start asserted again while in RUN (at pc=3) must not restart
    for (int i = 0; i < 5; i++) begin
      bus.start = (i == 3);
      tick();
    end
    bus.start = 1'b0;
    check_state("run5", 5, 1'b1, 1'b0, 5);

    // Backward branch: 5 + (-3) = 2
    bus.branch_taken = 1'b1; bus.branch_offset = 8'hFD;
    tick();
    check_state("br_back", 2, 1'b1, 1'b0, 6);
    bus.branch_taken = 1'b0;
    repeat (5) tick();
    check_state("run7", 7, 1'b1, 1'b0, 11);

    // Stall at pc=7 with a branch request that must be ignored
    bus.stall = 1'b1; bus.branch_taken = 1'b1; bus.branch_offset = 8'h10;
    #1;
    check("stall.valid_comb", 32'(bus.instr_valid), 32'h0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check_state("stall", 7, 1'b0, 1'b0, 11);
    end
    bus.stall = 1'b0; bus.branch_offset = 8'h05;
    #1;
    check("unstall.valid", 32'(bus.instr_valid), 32'h1);
    tick();
    check_state("br_after_stall", 12, 1'b1, 1'b0, 12);

    // Offset 0 self-loop
    bus.branch_offset = 8'h00;
    tick(); check_state("self_loop", 12, 1'b1, 1'b0, 13);
    // 12 - 128 wraps below zero to 908
    bus.branch_offset = 8'h80;
    tick(); check_state("wrap_low", 908, 1'b1, 1'b0, 14);
    // 908 + 112 = 1020
    bus.branch_offset = 8'h70;
    tick(); check_state("to_1020", 1020, 1'b1, 1'b0, 15);
    // 1020 + 8 wraps past max to 4
    imem[4] = 9'h1FF;
    bus.branch_offset = 8'h08;
    tick(); check_state("wrap_high", 4, 1'b1, 1'b0, 16);
    check("halt.instr", 32'(bus.instr), 32'h1FF);

    // HALT with branch_taken: HALT wins
    bus.branch_offset = 8'h10;
    tick(); check_state("collide", 4, 1'b0, 1'b1, 17);
    bus.branch_taken = 1'b0;
    tick(); check_state("collide_hold", 4, 1'b0, 1'b1, 17);

    // Restart, then asynchronous reset mid-RUN
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    check_state("restart2", 0, 1'b1, 1'b0, 0);
    tick(); check_state("run_pre_rst", 1, 1'b1, 1'b0, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check_state("async_rst", 0, 1'b0, 1'b0, 0);
    check("async_rst.instr", 32'(bus.instr), 32'h0);
    tick();
    rst_n = 1'b1;
    tick();
    check_state("post_rst", 0, 1'b0, 1'b0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
